// File: rtl/clock_divider_3phase.sv
// clock_divider_3phase
// Three-phase clock generator: derives the 6502 phase clock (cpu_phi), the
// memory clock (mem_phi) and the video clock (vid_phi) from CLOCK_50, plus
// single-cycle CLOCK_50-domain strobes at the cpu_phi edges.
//
// Every output is a flop loaded from the decode of the next counter value,
// so each output always equals the decode of the current cnt/vcnt with no
// combinational path to the pins.
//
// Optional feature macro: CLKDIV_STEP_EN
//   When defined, step_mode/step_req ports exist and the CPU counter can be
//   parked at 0 and released one full CPU cycle at a time. vid_phi is never
//   affected. When undefined, the block always free-runs.

module clock_divider_3phase #(
  parameter int CPU_DIV   = 50,
  parameter int MEM_RISE  = 35,
  parameter int MEM_WIDTH = 10,
  parameter int VID_DIV   = 2
) (
  input  logic CLOCK_50,
  input  logic res_n,
`ifdef CLKDIV_STEP_EN
  input  logic step_mode,
  input  logic step_req,
`endif
  output logic cpu_phi,
  output logic mem_phi,
  output logic vid_phi,
  output logic cpu_rise_stb,
  output logic cpu_fall_stb
);

  // Counter widths are clamped to 1 so that illegal parameters still reach
  // the elaboration checks below instead of failing on a zero-width vector.
  localparam int CW = (CPU_DIV > 2) ? $clog2(CPU_DIV) : 1;
  localparam int VW = (VID_DIV > 2) ? $clog2(VID_DIV) : 1;

  localparam int CPU_HALF = CPU_DIV / 2;
  localparam int MEM_END  = MEM_RISE + MEM_WIDTH;
  // vid_phi is low for the first ceil(VID_DIV/2) counts, high for the rest.
  localparam int VID_HIGH_FROM = VID_DIV - (VID_DIV / 2);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CPU_DIV - 1);
  localparam logic [VW-1:0] VCNT_LAST = VW'(VID_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [VW-1:0] VCNT_ONE  = VW'(1);

  // Reject illegal configurations at elaboration time.
  if (CPU_DIV < 4 || (CPU_DIV % 2) != 0) begin : g_bad_cpu_div
    $error("clock_divider_3phase: CPU_DIV must be even and >= 4");
  end
  if (MEM_RISE < CPU_HALF) begin : g_bad_mem_rise
    $error("clock_divider_3phase: MEM_RISE must be >= CPU_DIV/2");
  end
  if (MEM_WIDTH < 1) begin : g_bad_mem_width
    $error("clock_divider_3phase: MEM_WIDTH must be >= 1");
  end
  if (MEM_END > CPU_DIV) begin : g_bad_mem_end
    $error("clock_divider_3phase: MEM_RISE+MEM_WIDTH must be <= CPU_DIV");
  end
  if (VID_DIV < 2) begin : g_bad_vid_div
    $error("clock_divider_3phase: VID_DIV must be >= 2");
  end

  // Output decodes of a counter value; shared by every registered output.
  function automatic logic cpu_decode(input logic [CW-1:0] c);
    return (int'(c) >= CPU_HALF);
  endfunction

  function automatic logic mem_decode(input logic [CW-1:0] c);
    return (int'(c) >= MEM_RISE) && (int'(c) < MEM_END);
  endfunction

  function automatic logic rise_decode(input logic [CW-1:0] c);
    return (int'(c) == CPU_HALF);
  endfunction

  function automatic logic vid_decode(input logic [VW-1:0] v);
    return (int'(v) >= VID_HIGH_FROM);
  endfunction

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [VW-1:0] vcnt;
  logic [VW-1:0] vcnt_nxt;
  logic          advance;
  logic          wrap;

`ifdef CLKDIV_STEP_EN
  // step_req comes from a panel switch: two flops bring it into the
  // CLOCK_50 domain, the third remembers the previous sample for edge detect.
  logic step_req_p0;
  logic step_req_p1;
  logic step_req_p2;
  logic step_edge;

  // Synchronise and delay step_req for rising-edge detection.
  always_ff @(posedge CLOCK_50 or negedge res_n) begin
    if (!res_n) begin
      step_req_p0 <= 1'b0;
      step_req_p1 <= 1'b0;
      step_req_p2 <= 1'b0;
    end else begin
      step_req_p0 <= step_req;
      step_req_p1 <= step_req_p0;
      step_req_p2 <= step_req_p1;
    end
  end

  assign step_edge = step_req_p1 & ~step_req_p2;

  // The counter only parks at 0; once released it always finishes the
  // cycle, which is why edges arriving mid-cycle are simply not looked at.
  always_comb begin
    advance = 1'b1;
    if (step_mode && (cnt == '0)) begin
      advance = step_edge;
    end
  end
`else
  // Free-running build: the CPU counter advances every cycle.
  always_comb begin
    advance = 1'b1;
  end
`endif

  // Next-state decode for both counters and the wrap event.
  always_comb begin
    cnt_nxt  = cnt;
    wrap     = 1'b0;
    if (advance) begin
      if (cnt == CNT_LAST) begin
        cnt_nxt = '0;
        wrap    = 1'b1;
      end else begin
        cnt_nxt = cnt + CNT_ONE;
      end
    end
    if (vcnt == VCNT_LAST) begin
      vcnt_nxt = '0;
    end else begin
      vcnt_nxt = vcnt + VCNT_ONE;
    end
  end

  // CPU and video counters.
  always_ff @(posedge CLOCK_50 or negedge res_n) begin
    if (!res_n) begin
      cnt  <= '0;
      vcnt <= '0;
    end else begin
      cnt  <= cnt_nxt;
      vcnt <= vcnt_nxt;
    end
  end

  // Registered outputs loaded from the decode of the next counter values;
  // cpu_fall_stb keys off the wrap itself so the post-reset cnt=0 is silent.
  always_ff @(posedge CLOCK_50 or negedge res_n) begin
    if (!res_n) begin
      cpu_phi      <= 1'b0;
      mem_phi      <= 1'b0;
      vid_phi      <= 1'b0;
      cpu_rise_stb <= 1'b0;
      cpu_fall_stb <= 1'b0;
    end else begin
      cpu_phi      <= cpu_decode(cnt_nxt);
      mem_phi      <= mem_decode(cnt_nxt);
      vid_phi      <= vid_decode(vcnt_nxt);
      cpu_rise_stb <= rise_decode(cnt_nxt);
      cpu_fall_stb <= wrap;
    end
  end

endmodule

// File: tb/tb_clock_divider_3phase.sv
// Testbench for clock_divider_3phase: a default-parameter instance and a
// small instance (CPU_DIV=4, MEM_RISE=2, MEM_WIDTH=1, VID_DIV=3) compared
// against a time-since-reset reference model with randomized run lengths
// and randomized asynchronous reset points.
module tb_clock_divider_3phase;

  logic clk;
  logic res_n;

  logic cpu_phi_a, mem_phi_a, vid_phi_a, rise_a, fall_a;
  logic cpu_phi_b, mem_phi_b, vid_phi_b, rise_b, fall_b;
  logic [4:0] obs_a;
  logic [4:0] obs_b;

`ifdef CLKDIV_STEP_EN
  logic step_mode_a, step_req_a;
  logic step_mode_b, step_req_b;
`endif

  int errors = 0;
  int checks = 0;
  int t = 0;  // rising edges since the last reset release

  clock_divider_3phase dut_a (
    .CLOCK_50    (clk),
    .res_n       (res_n),
`ifdef CLKDIV_STEP_EN
    .step_mode   (step_mode_a),
    .step_req    (step_req_a),
`endif
    .cpu_phi     (cpu_phi_a),
    .mem_phi     (mem_phi_a),
    .vid_phi     (vid_phi_a),
    .cpu_rise_stb(rise_a),
    .cpu_fall_stb(fall_a)
  );

  clock_divider_3phase #(
    .CPU_DIV  (4),
    .MEM_RISE (2),
    .MEM_WIDTH(1),
    .VID_DIV  (3)
  ) dut_b (
    .CLOCK_50    (clk),
    .res_n       (res_n),
`ifdef CLKDIV_STEP_EN
    .step_mode   (step_mode_b),
    .step_req    (step_req_b),
`endif
    .cpu_phi     (cpu_phi_b),
    .mem_phi     (mem_phi_b),
    .vid_phi     (vid_phi_b),
    .cpu_rise_stb(rise_b),
    .cpu_fall_stb(fall_b)
  );

  assign obs_a = {cpu_phi_a, mem_phi_a, vid_phi_a, rise_a, fall_a};
  assign obs_b = {cpu_phi_b, mem_phi_b, vid_phi_b, rise_b, fall_b};

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Expected {cpu_phi, mem_phi, vid_phi, rise_stb, fall_stb} after tt
  // free-running edges since reset release.
  function automatic logic [4:0] model(input int tt, input int div,
                                       input int mr, input int mw,
                                       input int vd);
    int c;
    int v;
    logic [4:0] r;
    c = tt % div;
    v = tt % vd;
    r[4] = (c >= div / 2);
    r[3] = (c >= mr) && (c < mr + mw);
    r[2] = (v >= vd - vd / 2);
    r[1] = (c == div / 2);
    r[0] = (tt > 0) && (c == 0);
    return r;
  endfunction

  // Advance one clock: count the edge if out of reset, then settle to negedge.
  task automatic tick();
    @(posedge clk);
    if (res_n) t = t + 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    res_n = 1'b0;
    t = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs_a !== 5'b0) begin
        errors++;
        $display("FAIL reset_a: got %b expected %b", obs_a, 5'b0);
      end
      checks++;
      if (obs_b !== 5'b0) begin
        errors++;
        $display("FAIL reset_b: got %b expected %b", obs_b, 5'b0);
      end
    end
  endtask

  task automatic test_free_run();
    int first_rise;
    int n_rise;
    int n_fall;
    first_rise = -1;
    n_rise = 0;
    n_fall = 0;
    res_n = 1'b1;  // released at a negedge
    t = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      checks++;
      if (obs_a !== model(t, 50, 35, 10, 2)) begin
        errors++;
        $display("FAIL free_run_a: got %b expected %b at t=%0d",
                 obs_a, model(t, 50, 35, 10, 2), t);
      end
      checks++;
      if (obs_b !== model(t, 4, 2, 1, 3)) begin
        errors++;
        $display("FAIL free_run_b: got %b expected %b at t=%0d",
                 obs_b, model(t, 4, 2, 1, 3), t);
      end
      if (cpu_phi_a === 1'b1 && first_rise < 0) first_rise = t;
      if (rise_a === 1'b1) n_rise++;
      if (fall_a === 1'b1) n_fall++;
    end
    checks++;
    if (first_rise !== 25) begin
      errors++;
      $display("FAIL first_rise: got %0d expected %0d", first_rise, 25);
    end
    checks++;
    if (n_rise !== 4) begin
      errors++;
      $display("FAIL rise_count: got %0d expected %0d", n_rise, 4);
    end
    checks++;
    if (n_fall !== 4) begin
      errors++;
      $display("FAIL fall_count: got %0d expected %0d", n_fall, 4);
    end
  endtask

  task automatic test_reset_mid_cycle();
    int guard;
    int wait_cnt;
    guard = 0;
    while ((t % 50) != 40 && guard < 100) begin
      tick();
      guard++;
    end
    checks++;
    if (mem_phi_a !== 1'b1) begin
      errors++;
      $display("FAIL mid_mem_high: got %b expected %b at t=%0d", mem_phi_a, 1'b1, t);
    end
    #3;
    res_n = 1'b0;
    #1;
    checks++;
    if (obs_a !== 5'b0) begin
      errors++;
      $display("FAIL async_clear_a: got %b expected %b", obs_a, 5'b0);
    end
    checks++;
    if (obs_b !== 5'b0) begin
      errors++;
      $display("FAIL async_clear_b: got %b expected %b", obs_b, 5'b0);
    end
    t = 0;
    tick();
    tick();
    res_n = 1'b1;
    wait_cnt = 0;
    while (cpu_phi_a !== 1'b1 && wait_cnt < 60) begin
      tick();
      wait_cnt++;
      checks++;
      if (obs_a !== model(t, 50, 35, 10, 2)) begin
        errors++;
        $display("FAIL after_reset_a: got %b expected %b at t=%0d",
                 obs_a, model(t, 50, 35, 10, 2), t);
      end
    end
    checks++;
    if (wait_cnt !== 25) begin
      errors++;
      $display("FAIL rise_after_reset: got %0d expected %0d", wait_cnt, 25);
    end
  endtask

  task automatic test_random_resets();
    int n;
    for (int k = 0; k < 5; k++) begin
      n = $urandom_range(1, 150);
      for (int i = 0; i < n; i++) begin
        tick();
        checks++;
        if (obs_a !== model(t, 50, 35, 10, 2)) begin
          errors++;
          $display("FAIL rand_a: got %b expected %b at t=%0d",
                   obs_a, model(t, 50, 35, 10, 2), t);
        end
        checks++;
        if (obs_b !== model(t, 4, 2, 1, 3)) begin
          errors++;
          $display("FAIL rand_b: got %b expected %b at t=%0d",
                   obs_b, model(t, 4, 2, 1, 3), t);
        end
      end
      #($urandom_range(1, 8));
      res_n = 1'b0;
      #1;
      checks++;
      if ({obs_a, obs_b} !== 10'b0) begin
        errors++;
        $display("FAIL rand_async_clear: got %b expected %b", {obs_a, obs_b}, 10'b0);
      end
      t = 0;
      tick();
      res_n = 1'b1;
    end
  endtask

`ifdef CLKDIV_STEP_EN
  task automatic test_step();
    int cpu_hi;
    int mem_hi;
    int mem_rises;
    int n_rise;
    int n_fall;
    int seen_hi;
    int second_sent;
    int wait_cnt;
    logic mem_prev;
    res_n = 1'b0;
    step_mode_a = 1'b1;
    step_req_a = 1'b0;
    tick();
    res_n = 1'b1;
    t = 0;
    // Parked at cnt=0: CPU outputs quiet, video keeps running.
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++;
      if ({cpu_phi_a, mem_phi_a, rise_a, fall_a} !== 4'b0 ||
          vid_phi_a !== model(t, 50, 35, 10, 2)[2]) begin
        errors++;
        $display("FAIL step_hold: got %b expected cpu/mem/stb 0 vid %b at t=%0d",
                 obs_a, model(t, 50, 35, 10, 2)[2], t);
      end
    end
    cpu_hi = 0; mem_hi = 0; mem_rises = 0; n_rise = 0; n_fall = 0;
    seen_hi = 0; second_sent = 0; mem_prev = 1'b0;
    step_req_a = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (i == 2) step_req_a = 1'b0;
      if (cpu_phi_a === 1'b1) begin
        cpu_hi++;
        seen_hi++;
      end
      if (seen_hi == 5 && second_sent == 0) begin
        step_req_a = 1'b1;
        second_sent = 1;
      end else if (second_sent == 1 && seen_hi == 8) begin
        step_req_a = 1'b0;
      end
      if (mem_phi_a === 1'b1) mem_hi++;
      if (mem_phi_a === 1'b1 && mem_prev === 1'b0) mem_rises++;
      mem_prev = mem_phi_a;
      if (rise_a === 1'b1) n_rise++;
      if (fall_a === 1'b1) n_fall++;
      checks++;
      if (vid_phi_a !== model(t, 50, 35, 10, 2)[2]) begin
        errors++;
        $display("FAIL step_vid: got %b expected %b at t=%0d",
                 vid_phi_a, model(t, 50, 35, 10, 2)[2], t);
      end
    end
    step_req_a = 1'b0;
    checks++;
    if (cpu_hi !== 25) begin
      errors++;
      $display("FAIL step_cpu_high: got %0d expected %0d", cpu_hi, 25);
    end
    checks++;
    if (mem_hi !== 10 || mem_rises !== 1) begin
      errors++;
      $display("FAIL step_mem: got %0d cycles %0d pulses expected 10 cycles 1 pulse",
               mem_hi, mem_rises);
    end
    checks++;
    if (n_rise !== 1 || n_fall !== 1) begin
      errors++;
      $display("FAIL step_strobes: got rise %0d fall %0d expected 1 and 1", n_rise, n_fall);
    end
    // Leaving step mode resumes free running on the next edge.
    step_mode_a = 1'b0;
    wait_cnt = 0;
    while (cpu_phi_a !== 1'b1 && wait_cnt < 60) begin
      tick();
      wait_cnt++;
    end
    checks++;
    if (wait_cnt !== 25) begin
      errors++;
      $display("FAIL step_resume: got %0d expected %0d", wait_cnt, 25);
    end
  endtask
`endif

  initial begin
    res_n = 1'b0;
`ifdef CLKDIV_STEP_EN
    step_mode_a = 1'b0;
    step_req_a = 1'b0;
    step_mode_b = 1'b0;
    step_req_b = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_free_run();
    test_reset_mid_cycle();
    test_random_resets();
`ifdef CLKDIV_STEP_EN
    test_step();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
